// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg : shared encodings for the fetch stage (pc_sel, IF FSM)      |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cpu_pkg;

  localparam logic [2:0] PC_SEL_NPC    = 3'd0;
  localparam logic [2:0] PC_SEL_BRANCH = 3'd1;
  localparam logic [2:0] PC_SEL_JUMP   = 3'd2;
  localparam logic [2:0] PC_SEL_JR     = 3'd3;
  localparam logic [2:0] PC_SEL_EXC    = 3'd4;

  typedef enum logic [1:0] {
    IF_FETCH = 2'd0,
    IF_HOLD  = 2'd1,
    IF_DRAIN = 2'd2
  } if_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] SEQ_INC_DEFAULT  = 32'd4;

endpackage
`default_nettype wire

// File: rtl/if_pc_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_pc_mux : sequential PC and word-aligned redirect target select    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module if_pc_mux
  import cpu_pkg::*;
#(
  parameter logic [31:0] SEQ_INC = SEQ_INC_DEFAULT
) (
  input  logic [2:0]  pc_sel,
  input  logic [31:0] pc,
  input  logic [31:0] pc_baddr,
  input  logic [31:0] pc_jaddr,
  input  logic [31:0] pc_raddr,
  input  logic [31:0] pc_eaddr,
  output logic [31:0] seq_pc,
  output logic [31:0] target,
  output logic        is_redirect
);

  logic [31:0] sel_addr;

  always_comb begin
    seq_pc      = pc + SEQ_INC;
    sel_addr    = seq_pc;
    is_redirect = 1'b1;
    case (pc_sel)
      PC_SEL_BRANCH: sel_addr = pc_baddr;
      PC_SEL_JUMP:   sel_addr = pc_jaddr;
      PC_SEL_JR:     sel_addr = pc_raddr;
      PC_SEL_EXC:    sel_addr = pc_eaddr;
      PC_SEL_NPC:    is_redirect = 1'b0;
      // encodings 5-7 fall back to sequential fetch
      default:       is_redirect = 1'b0;
    endcase
    target = sel_addr & ~32'h0000_0003;
  end

endmodule
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_stage : PC register, imem req/ack fetch FSM, skid + decode output |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] SEQ_INC  = SEQ_INC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [2:0]  pc_sel,
  input  logic [31:0] pc_baddr,
  input  logic [31:0] pc_jaddr,
  input  logic [31:0] pc_raddr,
  input  logic [31:0] pc_eaddr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_npc,
  output logic [31:0] id_instr,
  output logic [31:0] pc_out
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic [31:0] skid_npc_q, skid_npc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_npc_q, id_npc_d;
  logic [31:0] id_instr_q, id_instr_d;

  logic        consume;
  logic        redirect;
  logic        is_redirect;
  logic [31:0] seq_pc;
  logic [31:0] target;

  if_pc_mux #(
    .SEQ_INC (SEQ_INC)
  ) u_pc_mux (
    .pc_sel      (pc_sel),
    .pc          (pc_q),
    .pc_baddr    (pc_baddr),
    .pc_jaddr    (pc_jaddr),
    .pc_raddr    (pc_raddr),
    .pc_eaddr    (pc_eaddr),
    .seq_pc      (seq_pc),
    .target      (target),
    .is_redirect (is_redirect)
  );

  // pc_sel only matters when decode actually takes the current slot
  assign consume  = id_valid_q & ~stall;
  assign redirect = consume & is_redirect;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    skid_npc_d   = skid_npc_q;
    skid_instr_d = skid_instr_q;
    id_valid_d   = id_valid_q;
    id_npc_d     = id_npc_q;
    id_instr_d   = id_instr_q;

    case (state_q)
      IF_FETCH: begin
        if (redirect) begin
          pc_d       = target;
          id_valid_d = 1'b0;
          id_instr_d = '0;
          // request still outstanding: keep its address stable until ack
          if (!imem_ack) begin
            drain_addr_d = pc_q;
            state_d      = IF_DRAIN;
          end
        end else if (imem_ack) begin
          pc_d = seq_pc;
          if (!id_valid_q || consume) begin
            id_valid_d = 1'b1;
            id_npc_d   = seq_pc;
            id_instr_d = imem_rdata;
          end else begin
            skid_npc_d   = seq_pc;
            skid_instr_d = imem_rdata;
            state_d      = IF_HOLD;
          end
        end else if (consume) begin
          id_valid_d = 1'b0;
          id_instr_d = '0;
        end
      end

      IF_HOLD: begin
        if (consume) begin
          state_d = IF_FETCH;
          if (redirect) begin
            pc_d       = target;
            id_valid_d = 1'b0;
            id_instr_d = '0;
          end else begin
            id_valid_d = 1'b1;
            id_npc_d   = skid_npc_q;
            id_instr_d = skid_instr_q;
          end
        end
      end

      IF_DRAIN: begin
        if (imem_ack) begin
          state_d = IF_FETCH;
        end
      end

      default: state_d = IF_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IF_FETCH;
      pc_q         <= RESET_PC;
      drain_addr_q <= '0;
      skid_npc_q   <= '0;
      skid_instr_q <= '0;
      id_valid_q   <= 1'b0;
      id_npc_q     <= '0;
      id_instr_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      skid_npc_q   <= skid_npc_d;
      skid_instr_q <= skid_instr_d;
      id_valid_q   <= id_valid_d;
      id_npc_q     <= id_npc_d;
      id_instr_q   <= id_instr_d;
    end
  end

  assign imem_req  = ~rst & (state_q != IF_HOLD);
  assign imem_addr = ((state_q == IF_DRAIN) ? drain_addr_q : pc_q) & ~32'h0000_0003;
  assign id_valid  = id_valid_q;
  assign id_npc    = id_npc_q;
  assign id_instr  = id_valid_q ? id_instr_q : '0;
  assign pc_out    = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_if_stage : directed bench for if_stage, memory returns addr as data|
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [2:0]  pc_sel;
  logic [31:0] pc_baddr;
  logic [31:0] pc_jaddr;
  logic [31:0] pc_raddr;
  logic [31:0] pc_eaddr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_npc;
  logic [31:0] id_instr;
  logic [31:0] pc_out;

  logic        ack_en;
  int          n_err;
  int          n_checks;

  if_stage dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .pc_sel     (pc_sel),
    .pc_baddr   (pc_baddr),
    .pc_jaddr   (pc_jaddr),
    .pc_raddr   (pc_raddr),
    .pc_eaddr   (pc_eaddr),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_npc     (id_npc),
    .id_instr   (id_instr),
    .pc_out     (pc_out)
  );

  // zero-latency memory when enabled; data is the word address itself
  assign imem_ack   = ack_en & imem_req;
  assign imem_rdata = imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    n_err = 0; n_checks = 0;
    rst = 1'b1; stall = 1'b0; pc_sel = 3'd0; ack_en = 1'b1;
    pc_baddr = '0; pc_jaddr = '0; pc_raddr = '0; pc_eaddr = '0;
    tick(); tick();
    chk("rst_req",    {31'd0, imem_req}, 32'd0);
    chk("rst_valid",  {31'd0, id_valid}, 32'd0);
    chk("rst_instr",  id_instr,          32'd0);
    chk("rst_npc",    id_npc,            32'd0);
    chk("rst_pc",     pc_out,            32'h0040_0000);

    // 1: back-to-back zero-latency fetches
    rst = 1'b0;
    #1;
    chk("t1_req",     {31'd0, imem_req}, 32'd1);
    chk("t1_addr0",   imem_addr,         32'h0040_0000);
    chk("t1_valid0",  {31'd0, id_valid}, 32'd0);
    tick();
    chk("t1_valid1",  {31'd0, id_valid}, 32'd1);
    chk("t1_npc1",    id_npc,            32'h0040_0004);
    chk("t1_instr1",  id_instr,          32'h0040_0000);
    chk("t1_addr1",   imem_addr,         32'h0040_0004);
    tick();
    chk("t1_npc2",    id_npc,            32'h0040_0008);
    chk("t1_addr2",   imem_addr,         32'h0040_0008);

    // 2: stall fills the skid, release replays it
    stall = 1'b1;
    tick();
    chk("t2_hold_req", {31'd0, imem_req}, 32'd0);
    chk("t2_hold_npc", id_npc,            32'h0040_0008);
    chk("t2_hold_pc",  pc_out,            32'h0040_000C);
    tick();
    chk("t2_hold_req2", {31'd0, imem_req}, 32'd0);
    tick();
    stall = 1'b0;
    tick();
    chk("t2_skid_npc",   id_npc,   32'h0040_000C);
    chk("t2_skid_instr", id_instr, 32'h0040_0008);
    chk("t2_skid_addr",  imem_addr, 32'h0040_000C);
    tick();
    chk("t2_next_npc",   id_npc,   32'h0040_0010);
    chk("t2_next_instr", id_instr, 32'h0040_000C);

    // 3: branch with a slow ack goes through DRAIN
    ack_en = 1'b0; pc_sel = 3'd1; pc_baddr = 32'h0040_0100;
    tick();
    pc_sel = 3'd0;
    chk("t3_valid_a",  {31'd0, id_valid}, 32'd0);
    chk("t3_drain_req", {31'd0, imem_req}, 32'd1);
    chk("t3_drain_addr", imem_addr,       32'h0040_0010);
    chk("t3_pc",       pc_out,            32'h0040_0100);
    tick();
    chk("t3_valid_b",  {31'd0, id_valid}, 32'd0);
    tick();
    ack_en = 1'b1;
    tick();
    chk("t3_valid_c",  {31'd0, id_valid}, 32'd0);
    chk("t3_tgt_addr", imem_addr,         32'h0040_0100);
    tick();
    chk("t3_npc",      id_npc,            32'h0040_0104);
    chk("t3_instr",    id_instr,          32'h0040_0100);

    // 4: jump with same-cycle ack, then aligned register jump
    pc_sel = 3'd2; pc_jaddr = 32'h0040_0040;
    tick();
    pc_sel = 3'd0;
    chk("t4_j_valid",  {31'd0, id_valid}, 32'd0);
    chk("t4_j_instr",  id_instr,          32'd0);
    chk("t4_j_addr",   imem_addr,         32'h0040_0040);
    tick();
    chk("t4_j_npc",    id_npc,            32'h0040_0044);
    pc_sel = 3'd3; pc_raddr = 32'h0040_0203;
    tick();
    pc_sel = 3'd0;
    chk("t4_jr_addr",  imem_addr,         32'h0040_0200);
    chk("t4_jr_valid", {31'd0, id_valid}, 32'd0);
    tick();
    chk("t4_jr_npc",   id_npc,            32'h0040_0204);

    // 5: exception redirect held off by stall; invalid pc_sel is sequential
    stall = 1'b1; pc_sel = 3'd4; pc_eaddr = 32'h0040_0004;
    tick();
    chk("t5_stall_npc", id_npc,           32'h0040_0204);
    chk("t5_stall_pc",  pc_out,           32'h0040_0208);
    stall = 1'b0;
    tick();
    pc_sel = 3'd6;
    chk("t5_exc_valid", {31'd0, id_valid}, 32'd0);
    chk("t5_exc_addr",  imem_addr,        32'h0040_0004);
    tick();
    chk("t5_exc_npc",   id_npc,           32'h0040_0008);
    chk("t5_exc_instr", id_instr,         32'h0040_0004);
    tick();
    chk("t5_sel6_npc",  id_npc,           32'h0040_000C);
    chk("t5_sel6_pc",   pc_out,           32'h0040_000C);
    pc_sel = 3'd0;

    // 6: reset during DRAIN, reset with skid full, PC wrap
    ack_en = 1'b0; pc_sel = 3'd1; pc_baddr = 32'h0040_0100;
    tick();
    pc_sel = 3'd0;
    chk("t6_drain_addr", imem_addr,       32'h0040_000C);
    rst = 1'b1;
    tick();
    chk("t6_r1_pc",    pc_out,            32'h0040_0000);
    chk("t6_r1_valid", {31'd0, id_valid}, 32'd0);
    chk("t6_r1_instr", id_instr,          32'd0);
    chk("t6_r1_req",   {31'd0, imem_req}, 32'd0);
    rst = 1'b0; ack_en = 1'b1;
    #1;
    chk("t6_r1_addr",  imem_addr,         32'h0040_0000);
    tick();
    chk("t6_r1_npc",   id_npc,            32'h0040_0004);
    stall = 1'b1;
    tick();
    chk("t6_skid_req", {31'd0, imem_req}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0; stall = 1'b0;
    #1;
    chk("t6_r2_valid", {31'd0, id_valid}, 32'd0);
    chk("t6_r2_instr", id_instr,          32'd0);
    chk("t6_r2_pc",    pc_out,            32'h0040_0000);
    chk("t6_r2_req",   {31'd0, imem_req}, 32'd1);
    tick();
    chk("t6_r2_npc",   id_npc,            32'h0040_0004);
    pc_sel = 3'd4; pc_eaddr = 32'hFFFF_FFFF;
    tick();
    pc_sel = 3'd0;
    chk("t6_wrap_pc",  pc_out,            32'hFFFF_FFFC);
    chk("t6_wrap_addr", imem_addr,        32'hFFFF_FFFC);
    tick();
    chk("t6_wrap_npc",  id_npc,           32'h0000_0000);
    chk("t6_wrap_instr", id_instr,        32'hFFFF_FFFC);
    chk("t6_wrap_pc0",  pc_out,           32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
